// File: rtl/seq_cont_pipe_checker.sv
// seq_cont_pipe_checker: net-vs-variable continuous-assign copies piped DEPTH stages and compared per channel
module seq_cont_pipe_checker #(
  parameter int WIDTH = 1,
  parameter int CHANNELS = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8,
  parameter int CYC_W = 16,
  localparam int N = CHANNELS * WIDTH,
  localparam int CH_W = $clog2(CHANNELS) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [N-1:0]              in_data,
  input  logic [N-1:0]              inj_mask,
  output logic [N-1:0]              out_net,
  output logic [N-1:0]              out_var,
  output logic                      out_valid,
  output logic [CHANNELS*CNT_W-1:0] mismatch_cnt,
  output logic                      err,
  output logic [CH_W-1:0]           first_err_chan,
  output logic [CYC_W-1:0]          first_err_cycle,
  output logic                      report_valid,
  input  logic                      report_ready
);
  typedef enum logic [1:0] {IDLE, RUN, REPORT, DONE} state_t;
  state_t r_state, w_next;
  wire  [N-1:0] w_net;
  logic [N-1:0] w_var;
  logic [DEPTH-1:0][N-1:0] r_net, r_var;
  logic [CHANNELS-1:0][CNT_W-1:0] r_cnt;
  logic [CYC_W-1:0] r_cyc, r_fcy;
  logic [CH_W-1:0] r_fch, w_low;
  logic [CHANNELS-1:0] w_mis;
  logic r_err, w_run, w_clr;
  assign w_net = in_data;
  assign w_var = in_data ^ inj_mask;
  assign w_run = r_state == RUN;
  assign w_clr = (r_state == IDLE || r_state == DONE) && start;
  assign out_net = r_net[DEPTH-1];
  assign out_var = r_var[DEPTH-1];
  assign out_valid = w_run && r_cyc >= CYC_W'(DEPTH);
  assign report_valid = r_state == REPORT;
  assign mismatch_cnt = r_cnt;
  assign err = r_err;
  assign first_err_chan = r_fch;
  assign first_err_cycle = r_fcy;
  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_mis
    assign w_mis[g] = out_net[g*WIDTH +: WIDTH] != out_var[g*WIDTH +: WIDTH];
  end
  // scan downward so the lowest mismatching channel wins
  always_comb begin
    w_low = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) if (w_mis[c]) w_low = CH_W'(c);
  end
  always_comb begin
    w_next = w_clr ? RUN : (w_run && stop) ? REPORT : (report_valid && report_ready) ? DONE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_net <= '0;
      r_var <= '0;
      r_cyc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_fch <= '0;
      r_fcy <= '0;
    end else if (w_run) begin
      r_net[0] <= w_net;
      r_var[0] <= w_var;
      for (int i = 1; i < DEPTH; i++) begin
        r_net[i] <= r_net[i-1];
        r_var[i] <= r_var[i-1];
      end
      if (r_cyc != '1) r_cyc <= r_cyc + 1'b1;
      if (out_valid) begin
        for (int c = 0; c < CHANNELS; c++) if (w_mis[c] && r_cnt[c] != '1) r_cnt[c] <= r_cnt[c] + 1'b1;
        if (|w_mis && !r_err) begin
          r_err <= 1'b1;
          r_fch <= w_low;
          r_fcy <= r_cyc;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_cont_pipe_checker.sv
// tb_seq_cont_pipe_checker: directed + random stimulus against a queue-based model; two DUTs (CNT_W 8 and 2)
module tb_seq_cont_pipe_checker;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, start = 0, stop = 0, report_ready = 0;
  logic [1:0] in_data = 0, inj_mask = 0;
  logic [1:0] a_net, a_var, b_net, b_var, a_fch, b_fch;
  logic a_valid, b_valid, a_err, b_err, a_rv, b_rv;
  logic [15:0] a_cnt, a_fcy, b_fcy;
  logic [3:0] b_cnt;
  int checks = 0, failures = 0;
  bit armed = 0;
  always #5 clk = ~clk;

  seq_cont_pipe_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_data(in_data), .inj_mask(inj_mask),
    .out_net(a_net), .out_var(a_var), .out_valid(a_valid), .mismatch_cnt(a_cnt), .err(a_err),
    .first_err_chan(a_fch), .first_err_cycle(a_fcy), .report_valid(a_rv), .report_ready(report_ready));

  seq_cont_pipe_checker #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_data(in_data), .inj_mask(inj_mask),
    .out_net(b_net), .out_var(b_var), .out_valid(b_valid), .mismatch_cnt(b_cnt), .err(b_err),
    .first_err_chan(b_fch), .first_err_cycle(b_fcy), .report_valid(b_rv), .report_ready(report_ready));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // model: phase 0 idle, 1 run, 2 report, 3 done; queues hold the last DEPTH sampled copies
  int ph, cyc, fch, fcy, lo;
  int cnt [2];
  bit err;
  logic [1:0] qn[$], qv[$];

  function automatic int sat(input int v, input int m);
    return v > m ? m : v;
  endfunction

  task automatic clr_model();
    cyc = 0; err = 0; fch = 0; fcy = 0; cnt[0] = 0; cnt[1] = 0;
    qn.delete(); qv.delete();
    repeat (DEPTH) begin qn.push_back(2'b00); qv.push_back(2'b00); end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; clr_model();
    end else if ((ph == 0 || ph == 3) && start) begin
      ph = 1; clr_model();
    end else if (ph == 1) begin
      if (cyc >= DEPTH) begin
        lo = -1;
        for (int c = 0; c < 2; c++) if (qn[0][c] != qv[0][c]) begin cnt[c]++; if (lo < 0) lo = c; end
        if (lo >= 0 && !err) begin err = 1; fch = lo; fcy = sat(cyc, 65535); end
      end
      qn.push_back(in_data); qv.push_back(in_data ^ inj_mask);
      void'(qn.pop_front()); void'(qv.pop_front());
      cyc++;
      if (stop) ph = 2;
    end else if (ph == 2 && report_ready) ph = 3;
  end

  always @(negedge clk) if (armed) begin
    chk("a_net", a_net, qn[0]);       chk("a_var", a_var, qv[0]);
    chk("b_net", b_net, qn[0]);       chk("b_var", b_var, qv[0]);
    chk("a_valid", a_valid, ph == 1 && cyc >= DEPTH);
    chk("b_valid", b_valid, ph == 1 && cyc >= DEPTH);
    chk("a_rv", a_rv, ph == 2);       chk("b_rv", b_rv, ph == 2);
    chk("a_cnt0", a_cnt[7:0], sat(cnt[0], 255));  chk("a_cnt1", a_cnt[15:8], sat(cnt[1], 255));
    chk("b_cnt0", b_cnt[1:0], sat(cnt[0], 3));    chk("b_cnt1", b_cnt[3:2], sat(cnt[1], 3));
    chk("a_err", a_err, err);         chk("b_err", b_err, err);
    chk("a_fch", a_fch, fch);         chk("b_fch", b_fch, fch);
    chk("a_fcy", a_fcy, fcy);         chk("b_fcy", b_fcy, fcy);
  end

  initial begin
    tick(); armed = 1; tick(); rst = 0; tick();
    chk("rst_valid", a_valid, 0); chk("rst_rv", a_rv, 0); chk("rst_err", a_err, 0);
    chk("rst_cnt", a_cnt, 0); chk("rst_net", a_net, 0); chk("rst_fcy", a_fcy, 0);
    start = 1; tick();                                  // RUN cyc0
    start = 0; in_data = 2'b01; tick();                 // cyc1
    in_data = 2'b10; tick();                            // cyc2
    chk("t1_valid", a_valid, 1); chk("t2_net01", a_net, 2'b01); chk("t2_var01", a_var, 2'b01);
    in_data = 2'b11; tick();                            // cyc3
    chk("t2_net10", a_net, 2'b10); chk("t2_var10", a_var, 2'b10);
    in_data = 2'b00; tick();                            // cyc4
    chk("t2_net11", a_net, 2'b11); chk("t2_var11", a_var, 2'b11);
    chk("t2_err", a_err, 0); chk("t2_cnt", a_cnt, 0);
    tick();                                             // cyc5
    inj_mask = 2'b10; repeat (3) tick();                // cyc8
    inj_mask = 2'b00; repeat (2) tick();                // cyc10
    chk("t3_cnt1", a_cnt[15:8], 3); chk("t3_cnt0", a_cnt[7:0], 0); chk("t3_err", a_err, 1);
    chk("t3_fch", a_fch, 1); chk("t3_fcy", a_fcy, 7); chk("t3_bcnt1", b_cnt[3:2], 3);
    inj_mask = 2'b11; repeat (6) tick();                // cyc16
    inj_mask = 2'b00; repeat (2) tick();                // cyc18
    chk("t4_bsat0", b_cnt[1:0], 3); chk("t4_bsat1", b_cnt[3:2], 3);
    chk("t4_acnt0", a_cnt[7:0], 6); chk("t4_acnt1", a_cnt[15:8], 9); chk("t4_fch_keep", a_fch, 1);
    stop = 1; tick();                                   // REPORT
    stop = 0; start = 1;
    repeat (3) begin
      tick(); chk("t5_rv_held", a_rv, 1); chk("t5_cnt_frozen", a_cnt[15:8], 9);
    end
    start = 0; report_ready = 1; tick();                // DONE
    chk("t5_rv_drop", a_rv, 0); chk("t5_err_hold", a_err, 1); chk("t5_fcy_hold", a_fcy, 7);
    report_ready = 0; stop = 1; tick();
    chk("t5_done_stop", a_rv, 0);
    stop = 0; start = 1; tick();                        // RUN cyc0
    chk("t5_clr_err", a_err, 0); chk("t5_clr_cnt", a_cnt, 0); chk("t5_clr_fcy", a_fcy, 0);
    start = 0; inj_mask = 2'b01; repeat (6) tick();     // cyc6
    inj_mask = 2'b00; repeat (2) tick();                // cyc8
    chk("t4_bsat", b_cnt[1:0], 3); chk("t4_acnt", a_cnt[7:0], 6);
    chk("t4_fch0", b_fch, 0); chk("t4_fcy2", a_fcy, 2);
    stop = 1; report_ready = 1; tick();                 // REPORT
    stop = 0; tick();                                   // DONE
    start = 1; inj_mask = 2'b01; tick();                // RUN cyc0
    start = 0; repeat (4) tick();                       // cyc4
    chk("t6_err_pre", a_err, 1);
    rst = 1; tick();
    chk("t6_err", a_err, 0); chk("t6_cnt", a_cnt, 0); chk("t6_net", a_net, 0); chk("t6_var", a_var, 0);
    chk("t6_valid", a_valid, 0); chk("t6_fcy", a_fcy, 0); chk("t6_rv", a_rv, 0);
    rst = 0; inj_mask = 0; start = 1; stop = 1; tick(); // RUN cyc0
    start = 0; stop = 0; chk("t6_ss_rv", a_rv, 0); tick(); tick();
    chk("t6_ss_valid", a_valid, 1);
    repeat (4000) begin
      start = $urandom_range(0, 19) == 0;
      stop = $urandom_range(0, 29) == 0;
      report_ready = $urandom_range(0, 2) == 0;
      rst = $urandom_range(0, 599) == 0;
      in_data = 2'($urandom);
      inj_mask = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
